// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI/HDMI path: x/y counters, syncs, blanking, line/frame strobes.
// Define VTG_EARLY_REQ_EN to add the o_req/o_req_x/o_req_y prefetch counter pair running REQ_LEAD ahead.
module video_timing_gen #(
  parameter  int unsigned H_ACTIVE = 640,
  parameter  int unsigned H_FP     = 16,
  parameter  int unsigned H_SYNC   = 96,
  parameter  int unsigned H_BP     = 48,
  parameter  int unsigned V_ACTIVE = 480,
  parameter  int unsigned V_FP     = 10,
  parameter  int unsigned V_SYNC   = 2,
  parameter  int unsigned V_BP     = 33,
  parameter  int unsigned HS_POL   = 0,
  parameter  int unsigned VS_POL   = 0,
  parameter  int unsigned REQ_LEAD = 2,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW       = $clog2(H_TOTAL),
  localparam int unsigned YW       = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_blanking,
  output logic [1:0]    o_control_data,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start
`ifdef VTG_EARLY_REQ_EN
  ,
  output logic          o_req,
  output logic [XW-1:0] o_req_x,
  output logic [YW-1:0] o_req_y
`endif
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic HS_ON = HS_POL[0];
  localparam logic VS_ON = VS_POL[0];

  if (REQ_LEAD == 0 || REQ_LEAD >= H_TOTAL) begin : g_bad_req_lead
    $error("video_timing_gen: REQ_LEAD must be in 1..H_TOTAL-1");
  end

  // h/v hold the position the next enabled clock will present on o_x/o_y.
  logic [XW-1:0] h, h_next;
  logic [YW-1:0] v, v_next;
  logic          hs_lvl, vs_lvl, active;

  always_comb begin
    h_next = h + 1'b1;
    v_next = v;
    if (h == H_LAST) begin
      h_next = '0;
      v_next = (v == V_LAST) ? '0 : v + 1'b1;
    end
    active = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hs_lvl = ((32'(h) >= HS_START) && (32'(h) < HS_END)) ? HS_ON : ~HS_ON;
    vs_lvl = ((32'(v) >= VS_START) && (32'(v) < VS_END)) ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h              <= '0;
      v              <= '0;
      o_x            <= '0;
      o_y            <= '0;
      o_blanking     <= 1'b1;
      o_hsync        <= ~HS_ON;
      o_vsync        <= ~VS_ON;
      o_control_data <= {~VS_ON, ~HS_ON};
      o_line_start   <= 1'b0;
      o_frame_start  <= 1'b0;
    end else if (i_enable) begin
      h              <= h_next;
      v              <= v_next;
      o_x            <= h;
      o_y            <= v;
      o_blanking     <= ~active;
      o_hsync        <= hs_lvl;
      o_vsync        <= vs_lvl;
      o_control_data <= {vs_lvl, hs_lvl};
      o_line_start   <= (h == '0);
      o_frame_start  <= (h == '0) && (v == '0);
    end
  end

`ifdef VTG_EARLY_REQ_EN
  logic [XW-1:0] rh, rh_next;
  logic [YW-1:0] rv, rv_next;
  logic          ractive;

  always_comb begin
    rh_next = rh + 1'b1;
    rv_next = rv;
    if (rh == H_LAST) begin
      rh_next = '0;
      rv_next = (rv == V_LAST) ? '0 : rv + 1'b1;
    end
    ractive = (32'(rh) < H_ACTIVE) && (32'(rv) < V_ACTIVE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rh      <= XW'(REQ_LEAD);
      rv      <= '0;
      o_req   <= 1'b0;
      o_req_x <= XW'(REQ_LEAD);
      o_req_y <= '0;
    end else if (i_enable) begin
      rh      <= rh_next;
      rv      <= rv_next;
      o_req   <= ractive;
      o_req_x <= rh;
      o_req_y <= rv;
    end
  end
`endif

endmodule
